// File: rtl/ctrl_pkg.sv
// Shared decode constants and the control bundle for the ID/EX decode stage.
// Zbb funct7 codes are only referenced when CTRL_ZBB_EN is defined.
package ctrl_pkg;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [6:0] F7_BASE       = 7'b0000000;
   localparam logic [6:0] F7_ALT        = 7'b0100000;
   localparam logic [6:0] F7_MULDIV     = 7'b0000001;
   localparam logic [6:0] F7_ZBB_MINMAX = 7'b0000101;
   localparam logic [6:0] F7_ZBB_ROT    = 7'b0110000;
   localparam logic [6:0] F7_ZBB_ORCB   = 7'b0010100;
   localparam logic [6:0] F7_ZBB_REV8   = 7'b0110100;

   typedef enum logic [1:0] {
      ALU_ADD    = 2'b00,
      ALU_BRANCH = 2'b01,
      ALU_R      = 2'b10,
      ALU_I      = 2'b11
   } alu_class_e;

   typedef enum logic [1:0] {
      ST_NONE = 2'b00,
      ST_BYTE = 2'b01,
      ST_HALF = 2'b10,
      ST_WORD = 2'b11
   } store_width_e;

   typedef struct packed {
      logic         mem_to_reg;
      store_width_e data_mem_we;
      logic         rd_we;
      logic         alu_src_b;
      logic         branch;
      logic         jump;
      alu_class_e   alu_op;
      logic         rs1_in_use;
      logic         rs2_in_use;
      logic         pc_operand;
      logic         illegal;
      logic [4:0]   rd;
      logic [4:0]   rs1;
      logic [4:0]   rs2;
   } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational RV32IM decode into a ctrl_bundle_t plus mul/div flags.
// Define CTRL_ZBB_EN to accept the Zbb encodings as legal ALU ops.
module ctrl_decode_comb
   import ctrl_pkg::*;
(
   input  logic [31:0]  instr_i,
   output ctrl_bundle_t bundle_o,
   output logic         is_muldiv_o,
   output logic         is_div_o
);

   logic [6:0] opcode;
   logic [6:0] funct7;
   logic [2:0] funct3;
   logic       r_legal;
   logic       i_legal;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];

   // Shift-immediate forms reuse funct7 as an opcode extension; other I-ops carry a plain immediate.
   always_comb begin
      r_legal = 1'b0;
      case (funct7)
         F7_BASE, F7_MULDIV: r_legal = 1'b1;
         F7_ALT: begin
            r_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
`ifdef CTRL_ZBB_EN
            r_legal = r_legal || (funct3 == 3'b100) || (funct3 == 3'b110) || (funct3 == 3'b111);
`endif
         end
`ifdef CTRL_ZBB_EN
         F7_ZBB_MINMAX, F7_ZBB_ROT: r_legal = 1'b1;
`endif
         default: r_legal = 1'b0;
      endcase

      i_legal = 1'b1;
      if (funct3 == 3'b001) begin
         i_legal = (funct7 == F7_BASE);
`ifdef CTRL_ZBB_EN
         i_legal = i_legal || (funct7 == F7_ZBB_ROT);
`endif
      end else if (funct3 == 3'b101) begin
         i_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
`ifdef CTRL_ZBB_EN
         i_legal = i_legal || (funct7 == F7_ZBB_ROT) || (funct7 == F7_ZBB_ORCB) ||
                   (funct7 == F7_ZBB_REV8);
`endif
      end
   end

   always_comb begin
      bundle_o     = '0;
      bundle_o.rd  = instr_i[11:7];
      bundle_o.rs1 = instr_i[19:15];
      bundle_o.rs2 = instr_i[24:20];
      is_muldiv_o  = 1'b0;
      is_div_o     = 1'b0;
      case (opcode)
         OPC_R: begin
            if (r_legal) begin
               bundle_o.rd_we      = 1'b1;
               bundle_o.rs1_in_use = 1'b1;
               bundle_o.rs2_in_use = 1'b1;
               bundle_o.alu_op     = ALU_R;
               is_muldiv_o         = (funct7 == F7_MULDIV);
               is_div_o            = (funct7 == F7_MULDIV) && funct3[2];
            end else begin
               bundle_o.illegal = 1'b1;
            end
         end
         OPC_IMM: begin
            if (i_legal) begin
               bundle_o.rd_we      = 1'b1;
               bundle_o.alu_src_b  = 1'b1;
               bundle_o.rs1_in_use = 1'b1;
               bundle_o.alu_op     = ALU_I;
            end else begin
               bundle_o.illegal = 1'b1;
            end
         end
         OPC_LOAD: begin
            bundle_o.mem_to_reg = 1'b1;
            bundle_o.rd_we      = 1'b1;
            bundle_o.alu_src_b  = 1'b1;
            bundle_o.rs1_in_use = 1'b1;
            bundle_o.alu_op     = ALU_ADD;
         end
         OPC_STORE: begin
            case (funct3)
               3'b000:  bundle_o.data_mem_we = ST_BYTE;
               3'b001:  bundle_o.data_mem_we = ST_HALF;
               3'b010:  bundle_o.data_mem_we = ST_WORD;
               default: bundle_o.illegal     = 1'b1;
            endcase
            if (!bundle_o.illegal) begin
               bundle_o.alu_src_b  = 1'b1;
               bundle_o.rs1_in_use = 1'b1;
               bundle_o.rs2_in_use = 1'b1;
               bundle_o.alu_op     = ALU_ADD;
            end
         end
         OPC_BRANCH: begin
            bundle_o.branch     = 1'b1;
            bundle_o.rs1_in_use = 1'b1;
            bundle_o.rs2_in_use = 1'b1;
            bundle_o.alu_op     = ALU_BRANCH;
         end
         OPC_LUI: begin
            bundle_o.rd_we     = 1'b1;
            bundle_o.alu_src_b = 1'b1;
         end
         OPC_AUIPC: begin
            bundle_o.rd_we      = 1'b1;
            bundle_o.alu_src_b  = 1'b1;
            bundle_o.pc_operand = 1'b1;
         end
         OPC_JAL: begin
            bundle_o.rd_we      = 1'b1;
            bundle_o.jump       = 1'b1;
            bundle_o.pc_operand = 1'b1;
            bundle_o.alu_src_b  = 1'b1;
         end
         OPC_JALR: begin
            bundle_o.rd_we      = 1'b1;
            bundle_o.jump       = 1'b1;
            bundle_o.alu_src_b  = 1'b1;
            bundle_o.rs1_in_use = 1'b1;
         end
         default: bundle_o.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered, handshaked ID/EX decode stage with mul/div issue blocking.
// Zbb decode is enabled by defining CTRL_ZBB_EN (see ctrl_decode_comb).
module ctrl_decode_stage
   import ctrl_pkg::*;
#(
   parameter int unsigned ALU_OP_W    = 2,
   parameter int unsigned MUL_LATENCY = 2,
   parameter int unsigned DIV_LATENCY = 33,
   parameter int unsigned CNT_W       = $clog2(DIV_LATENCY + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic [31:0]         instr_i,
   input  logic                flush_i,
   input  logic                ready_i,
   output logic                valid_o,
   output logic                mem_to_reg_o,
   output logic [1:0]          data_mem_we_o,
   output logic                rd_we_o,
   output logic                alu_src_b_o,
   output logic                branch_o,
   output logic                jump_o,
   output logic [ALU_OP_W-1:0] alu_op_o,
   output logic                rs1_in_use_o,
   output logic                rs2_in_use_o,
   output logic                pc_operand_o,
   output logic                md_start_o,
   output logic                md_busy_o,
   output logic                illegal_o,
   output logic [4:0]          rd_o,
   output logic [4:0]          rs1_o,
   output logic [4:0]          rs2_o
);

   ctrl_bundle_t     dec_bundle;
   logic             dec_is_muldiv;
   logic             dec_is_div;
   ctrl_bundle_t     ctrl_q, ctrl_d;
   logic             valid_q, valid_d;
   logic             md_start_q, md_start_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;

   ctrl_decode_comb u_decode (
      .instr_i     (instr_i),
      .bundle_o    (dec_bundle),
      .is_muldiv_o (dec_is_muldiv),
      .is_div_o    (dec_is_div)
   );

   assign md_busy_o = (cnt_q != '0);
   assign ready_o   = (!valid_q || ready_i) && !md_busy_o;
   assign accept    = valid_i && ready_o;

   // Flush never touches the busy counter: the unit already started must drain.
   always_comb begin
      ctrl_d     = ctrl_q;
      valid_d    = valid_q;
      md_start_d = md_start_q;
      cnt_d      = cnt_q;
      if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      if (flush_i) begin
         valid_d        = 1'b0;
         md_start_d     = 1'b0;
         ctrl_d.illegal = 1'b0;
      end else if (accept) begin
         ctrl_d     = dec_bundle;
         valid_d    = 1'b1;
         md_start_d = dec_is_muldiv;
         if (dec_is_muldiv) begin
            cnt_d = dec_is_div ? CNT_W'(DIV_LATENCY) : CNT_W'(MUL_LATENCY);
         end
      end else if (ready_i) begin
         valid_d        = 1'b0;
         md_start_d     = 1'b0;
         ctrl_d.illegal = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ctrl_q     <= '0;
         valid_q    <= 1'b0;
         md_start_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         valid_q    <= valid_d;
         md_start_q <= md_start_d;
         cnt_q      <= cnt_d;
      end
   end

   assign valid_o       = valid_q;
   assign md_start_o    = md_start_q;
   assign mem_to_reg_o  = ctrl_q.mem_to_reg;
   assign data_mem_we_o = ctrl_q.data_mem_we;
   assign rd_we_o       = ctrl_q.rd_we;
   assign alu_src_b_o   = ctrl_q.alu_src_b;
   assign branch_o      = ctrl_q.branch;
   assign jump_o        = ctrl_q.jump;
   assign alu_op_o      = ALU_OP_W'(ctrl_q.alu_op);
   assign rs1_in_use_o  = ctrl_q.rs1_in_use;
   assign rs2_in_use_o  = ctrl_q.rs2_in_use;
   assign pc_operand_o  = ctrl_q.pc_operand;
   assign illegal_o     = ctrl_q.illegal;
   assign rd_o          = ctrl_q.rd;
   assign rs1_o         = ctrl_q.rs1;
   assign rs2_o         = ctrl_q.rs2;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Self-checking bench for ctrl_decode_stage: vector table plus handshake/mul-div/flush/reset sequences.
// Expected bundles are queued at accept time and compared when EX consumes them.
module tb_ctrl_decode_stage;

   localparam int MUL_LAT = 2;
   localparam int DIV_LAT = 33;

   // Field order: mem_to_reg, data_mem_we[1:0], rd_we, alu_src_b, branch, jump,
   // alu_op[1:0], rs1_use, rs2_use, pc_operand, md_start, illegal
   localparam logic [13:0] E_ADD   = 14'b0_00_1_0_0_0_10_1_1_0_0_0;
   localparam logic [13:0] E_ADDI  = 14'b0_00_1_1_0_0_11_1_0_0_0_0;
   localparam logic [13:0] E_LW    = 14'b1_00_1_1_0_0_00_1_0_0_0_0;
   localparam logic [13:0] E_SB    = 14'b0_01_0_1_0_0_00_1_1_0_0_0;
   localparam logic [13:0] E_SH    = 14'b0_10_0_1_0_0_00_1_1_0_0_0;
   localparam logic [13:0] E_SW    = 14'b0_11_0_1_0_0_00_1_1_0_0_0;
   localparam logic [13:0] E_ILL   = 14'b0_00_0_0_0_0_00_0_0_0_0_1;
   localparam logic [13:0] E_BEQ   = 14'b0_00_0_0_1_0_01_1_1_0_0_0;
   localparam logic [13:0] E_LUI   = 14'b0_00_1_1_0_0_00_0_0_0_0_0;
   localparam logic [13:0] E_AUIPC = 14'b0_00_1_1_0_0_00_0_0_1_0_0;
   localparam logic [13:0] E_JAL   = 14'b0_00_1_1_0_1_00_0_0_1_0_0;
   localparam logic [13:0] E_JALR  = 14'b0_00_1_1_0_1_00_1_0_0_0_0;
   localparam logic [13:0] E_MD    = 14'b0_00_1_0_0_0_10_1_1_0_1_0;

   localparam logic [31:0] I_ADD = 32'h002081B3;
   localparam logic [31:0] I_SW  = 32'h0020A223;
   localparam logic [31:0] I_MUL = 32'h027302B3;
   localparam logic [31:0] I_DIV = 32'h027342B3;

   logic        clk_i   = 1'b0;
   logic        rst_ni  = 1'b0;
   logic        valid_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        ready_i = 1'b1;
   logic [31:0] instr_i = '0;
   logic        ready_o, valid_o, mem_to_reg_o, rd_we_o, alu_src_b_o, branch_o, jump_o;
   logic        rs1_in_use_o, rs2_in_use_o, pc_operand_o, md_start_o, md_busy_o, illegal_o;
   logic [1:0]  data_mem_we_o, alu_op_o;
   logic [4:0]  rd_o, rs1_o, rs2_o;

   int          errors = 0;
   int          checks = 0;
   logic [13:0] cur_exp = '0;
   logic [28:0] sb_q[$];

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [13:0] exp;
   } vec_t;
   vec_t vecs[$];

   ctrl_decode_stage #(
      .ALU_OP_W    (2),
      .MUL_LATENCY (MUL_LAT),
      .DIV_LATENCY (DIV_LAT)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .valid_i       (valid_i),
      .ready_o       (ready_o),
      .instr_i       (instr_i),
      .flush_i       (flush_i),
      .ready_i       (ready_i),
      .valid_o       (valid_o),
      .mem_to_reg_o  (mem_to_reg_o),
      .data_mem_we_o (data_mem_we_o),
      .rd_we_o       (rd_we_o),
      .alu_src_b_o   (alu_src_b_o),
      .branch_o      (branch_o),
      .jump_o        (jump_o),
      .alu_op_o      (alu_op_o),
      .rs1_in_use_o  (rs1_in_use_o),
      .rs2_in_use_o  (rs2_in_use_o),
      .pc_operand_o  (pc_operand_o),
      .md_start_o    (md_start_o),
      .md_busy_o     (md_busy_o),
      .illegal_o     (illegal_o),
      .rd_o          (rd_o),
      .rs1_o         (rs1_o),
      .rs2_o         (rs2_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [13:0] actBundle();
      return {mem_to_reg_o, data_mem_we_o, rd_we_o, alu_src_b_o, branch_o, jump_o, alu_op_o,
              rs1_in_use_o, rs2_in_use_o, pc_operand_o, md_start_o, illegal_o};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: pop on EX handshake, drop on flush, push on stage accept.
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         sb_q.delete();
      end else begin
         if (valid_o && ready_i) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_valid: valid_o=1 with empty scoreboard");
            end else begin
               checkOutput("sb_bundle", {actBundle(), rd_o, rs1_o, rs2_o}, sb_q.pop_front());
            end
         end
         if (flush_i) begin
            sb_q.delete();
         end else if (valid_i && ready_o) begin
            sb_q.push_back({cur_exp, instr_i[11:7], instr_i[19:15], instr_i[24:20]});
         end
      end
   end

   // Called at posedge+2; returns at posedge+2 right after the accepting edge.
   task automatic applyStimulus(input logic [31:0] instr, input logic [13:0] exp);
      int waited = 0;
      valid_i = 1'b1;
      instr_i = instr;
      cur_exp = exp;
      @(negedge clk_i);
      while (!ready_o && waited < 200) begin
         @(negedge clk_i);
         waited++;
      end
      if (!ready_o) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: ready_o=%b required 1", ready_o);
      end
      @(posedge clk_i);
      #2;
      valid_i = 1'b0;
   endtask

   task automatic measureBusy(input string name, input logic [31:0] instr, input int exp_low);
      int low = 0;
      applyStimulus(instr, E_MD);
      valid_i = 1'b1;
      instr_i = I_ADD;
      cur_exp = E_ADD;
      @(negedge clk_i);
      checkOutput({name, "_start"}, {md_start_o, md_busy_o, ready_o}, 3'b110);
      while (!ready_o && low < 100) begin
         low++;
         @(negedge clk_i);
         if (low == 1) checkOutput({name, "_pulse_end"}, md_start_o, 1'b0);
      end
      checkOutput({name, "_ready_low_cycles"}, low, exp_low);
      @(posedge clk_i);
      #2;
      valid_i = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int busy;

      vecs.push_back('{"add",   I_ADD,        E_ADD});
      vecs.push_back('{"addi",  32'h00C30293, E_ADDI});
      vecs.push_back('{"lw",    32'h00812203, E_LW});
      vecs.push_back('{"sb",    32'h00208023, E_SB});
      vecs.push_back('{"sh",    32'h00209023, E_SH});
      vecs.push_back('{"sw",    I_SW,         E_SW});
      vecs.push_back('{"st011", 32'h0020B023, E_ILL});
      vecs.push_back('{"beq",   32'h00208463, E_BEQ});
      vecs.push_back('{"lui",   32'h123453B7, E_LUI});
      vecs.push_back('{"auipc", 32'h00001097, E_AUIPC});
      vecs.push_back('{"jal",   32'h010000EF, E_JAL});
      vecs.push_back('{"jalr",  32'h00008067, E_JALR});
      vecs.push_back('{"sub",   32'h402081B3, E_ADD});
      vecs.push_back('{"f7alt_sll", 32'h402091B3, E_ILL});
      vecs.push_back('{"badop", 32'h0000007F, E_ILL});
      vecs.push_back('{"slli",  32'h00309093, E_ADDI});
`ifdef CTRL_ZBB_EN
      vecs.push_back('{"andn",  32'h4020F1B3, E_ADD});
      vecs.push_back('{"clz",   32'h60009093, E_ADDI});
`else
      vecs.push_back('{"andn",  32'h4020F1B3, E_ILL});
      vecs.push_back('{"clz",   32'h60009093, E_ILL});
`endif

      $display("[TB] reset");
      repeat (2) @(posedge clk_i);
      #2;
      checkOutput("reset_outputs", {valid_o, actBundle(), rd_o, rs1_o, rs2_o, md_busy_o}, '0);
      checkOutput("reset_ready", ready_o, 1'b1);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #2;

      ready_i = 1'b1;
      foreach (vecs[i]) applyStimulus(vecs[i].instr, vecs[i].exp);
      @(posedge clk_i);
      #2;

      measureBusy("mul", I_MUL, MUL_LAT);
      measureBusy("div", I_DIV, DIV_LAT);
      @(posedge clk_i);
      #2;

      $display("[TB] back-pressure hold");
      ready_i = 1'b0;
      applyStimulus(I_SW, E_SW);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         checkOutput("bp_hold", {valid_o, ready_o, actBundle(), rd_o, rs1_o, rs2_o},
                     {1'b1, 1'b0, E_SW, 5'd4, 5'd1, 5'd2});
         @(posedge clk_i);
         #2;
      end
      ready_i = 1'b1;
      @(posedge clk_i);
      #2;
      @(negedge clk_i);
      checkOutput("bp_release_clear", valid_o, 1'b0);
      @(posedge clk_i);
      #2;

      $display("[TB] flush with accept");
      valid_i = 1'b1;
      instr_i = I_ADD;
      cur_exp = E_ADD;
      flush_i = 1'b1;
      @(posedge clk_i);
      #2;
      valid_i = 1'b0;
      flush_i = 1'b0;
      @(negedge clk_i);
      checkOutput("flush_accept_dropped", {valid_o, ready_o}, 2'b01);
      @(posedge clk_i);
      #2;

      $display("[TB] flush while divider busy");
      ready_i = 1'b0;
      applyStimulus(I_DIV, E_MD);
      flush_i = 1'b1;
      @(posedge clk_i);
      #2;
      flush_i = 1'b0;
      @(negedge clk_i);
      checkOutput("flush_div_outputs", {valid_o, md_start_o, illegal_o, md_busy_o}, 4'b0001);
      ready_i = 1'b1;
      busy = 0;
      while (md_busy_o && busy < 100) begin
         busy++;
         @(negedge clk_i);
      end
      checkOutput("flush_div_drain_cycles", busy, DIV_LAT - 1);
      @(posedge clk_i);
      #2;

      $display("[TB] reset mid-divide");
      applyStimulus(I_DIV, E_MD);
      repeat (5) @(posedge clk_i);
      #2;
      rst_ni = 1'b0;
      #1;
      checkOutput("async_reset_outputs", {valid_o, actBundle(), rd_o, rs1_o, rs2_o, md_busy_o}, '0);
      @(posedge clk_i);
      #2;
      rst_ni = 1'b1;
      @(negedge clk_i);
      checkOutput("post_reset_ready", {ready_o, md_busy_o, valid_o}, 3'b100);

      checkOutput("sb_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
